// File: rtl/udp_rx_port_dispatch.sv
// UDP receive dispatcher: matches the header's destination port against a
// programmable port table and forwards the payload to one channel, or drops it.

module udp_port_entry #(
  parameter logic [15:0] P_RST_PORT = 16'h0808
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_wr,
  input  logic [15:0] i_port,
  input  logic        i_en,
  input  logic [15:0] i_dst,
  output logic        o_hit
);
  logic [15:0] port;
  logic        en;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      port <= P_RST_PORT;
      en   <= 1'b1;
    end else if (i_wr) begin
      port <= i_port;
      en   <= i_en;
    end
  end

  // Reads the registered entry, so a same-cycle write is not yet visible.
  assign o_hit = en && (port == i_dst);
endmodule

module udp_rx_port_dispatch #(
  parameter int          P_CH_NUM    = 4,
  parameter logic [15:0] P_BASE_PORT = 16'h0808
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_cfg_wr,
  input  logic [1:0]          i_cfg_addr,
  input  logic [15:0]         i_cfg_port,
  input  logic                i_cfg_en,
  input  logic [63:0]         s_axis_ip_data,
  input  logic [55:0]         s_axis_ip_user,
  input  logic [7:0]          s_axis_ip_keep,
  input  logic                s_axis_ip_last,
  input  logic                s_axis_ip_valid,
  output logic [63:0]         m_axis_ch_data,
  output logic [31:0]         m_axis_ch_user,
  output logic [7:0]          m_axis_ch_keep,
  output logic                m_axis_ch_last,
  output logic [P_CH_NUM-1:0] m_axis_ch_valid,
  output logic [15:0]         o_drop_cnt,
  output logic                o_abort
);
  typedef enum logic [1:0] {S_IDLE, S_FWD, S_DROP} state_t;

  state_t        state, state_nxt;
  logic [63:0]   r_data;
  logic [15:0]   r_len;
  logic [7:0]    r_keep;
  logic          r_last, r_valid;
  logic [P_CH_NUM-1:0] hit;
  logic          hit_any;
  logic [1:0]    hit_idx, sel;
  logic [15:0]   pay_cnt;
  logic          fwd, drop_inc, abort_nxt, latch;
  logic          unused_user;

  assign unused_user = ^s_axis_ip_user[39:0];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_data  <= '0;
      r_len   <= '0;
      r_keep  <= '0;
      r_last  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_data  <= s_axis_ip_data;
      r_len   <= s_axis_ip_user[55:40];
      r_keep  <= s_axis_ip_keep;
      r_last  <= s_axis_ip_last;
      r_valid <= s_axis_ip_valid;
    end
  end

  for (genvar k = 0; k < P_CH_NUM; k++) begin : g_ent
    udp_port_entry #(.P_RST_PORT(16'(P_BASE_PORT + k))) u_ent (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_wr   (i_cfg_wr && (i_cfg_addr == 2'(k))),
      .i_port (i_cfg_port),
      .i_en   (i_cfg_en),
      .i_dst  (r_data[47:32]),
      .o_hit  (hit[k])
    );
  end

  // Scan high to low so the lowest matching entry wins.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int k = P_CH_NUM - 1; k >= 0; k--) begin
      if (hit[k]) begin
        hit_any = 1'b1;
        hit_idx = 2'(k);
      end
    end
  end

  assign pay_cnt = (r_len < 16'd8) ? 16'd0 : r_len - 16'd8;

  always_comb begin
    state_nxt = state;
    fwd       = 1'b0;
    drop_inc  = 1'b0;
    abort_nxt = 1'b0;
    latch     = 1'b0;
    case (state)
      S_IDLE: if (r_valid) begin
        if (r_last)       drop_inc = 1'b1;
        else if (hit_any) begin
          latch     = 1'b1;
          state_nxt = S_FWD;
        end else          state_nxt = S_DROP;
      end
      S_FWD: if (!r_valid) begin
        abort_nxt = 1'b1;
        state_nxt = S_IDLE;
      end else begin
        fwd = 1'b1;
        if (r_last) state_nxt = S_IDLE;
      end
      S_DROP: if (!r_valid) begin
        abort_nxt = 1'b1;
        state_nxt = S_IDLE;
      end else if (r_last) begin
        drop_inc  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state           <= S_IDLE;
      sel             <= '0;
      m_axis_ch_data  <= '0;
      m_axis_ch_user  <= '0;
      m_axis_ch_keep  <= 8'hFF;
      m_axis_ch_last  <= 1'b0;
      m_axis_ch_valid <= '0;
      o_drop_cnt      <= '0;
      o_abort         <= 1'b0;
    end else begin
      state           <= state_nxt;
      o_abort         <= abort_nxt;
      m_axis_ch_last  <= fwd && r_last;
      m_axis_ch_valid <= fwd ? (P_CH_NUM'(1) << sel) : '0;
      m_axis_ch_keep  <= (fwd && r_last) ? r_keep : 8'hFF;
      if (fwd)      m_axis_ch_data <= r_data;
      if (drop_inc) o_drop_cnt     <= o_drop_cnt + 16'd1;
      // Channel and length are frozen at the header so table writes can't redirect.
      if (latch) begin
        sel            <= hit_idx;
        m_axis_ch_user <= {16'd0, pay_cnt};
      end
    end
  end
endmodule

// File: tb/tb_udp_rx_port_dispatch.sv
// Scoreboard bench for udp_rx_port_dispatch: expected beats, drops and aborts
// are queued with their due cycle and checked as the outputs appear.

module tb_udp_rx_port_dispatch;
  logic        i_clk = 0, i_rst = 1;
  logic        i_cfg_wr = 0, i_cfg_en = 0;
  logic [1:0]  i_cfg_addr = 0;
  logic [15:0] i_cfg_port = 0;
  logic [63:0] s_axis_ip_data = 0;
  logic [55:0] s_axis_ip_user = 0;
  logic [7:0]  s_axis_ip_keep = 0;
  logic        s_axis_ip_last = 0, s_axis_ip_valid = 0;
  logic [63:0] m_axis_ch_data;
  logic [31:0] m_axis_ch_user;
  logic [7:0]  m_axis_ch_keep;
  logic        m_axis_ch_last;
  logic [3:0]  m_axis_ch_valid;
  logic [15:0] o_drop_cnt;
  logic        o_abort;

  udp_rx_port_dispatch #(.P_CH_NUM(4), .P_BASE_PORT(16'h0808)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_cfg_wr(i_cfg_wr), .i_cfg_addr(i_cfg_addr),
    .i_cfg_port(i_cfg_port), .i_cfg_en(i_cfg_en),
    .s_axis_ip_data(s_axis_ip_data), .s_axis_ip_user(s_axis_ip_user),
    .s_axis_ip_keep(s_axis_ip_keep), .s_axis_ip_last(s_axis_ip_last),
    .s_axis_ip_valid(s_axis_ip_valid),
    .m_axis_ch_data(m_axis_ch_data), .m_axis_ch_user(m_axis_ch_user),
    .m_axis_ch_keep(m_axis_ch_keep), .m_axis_ch_last(m_axis_ch_last),
    .m_axis_ch_valid(m_axis_ch_valid), .o_drop_cnt(o_drop_cnt), .o_abort(o_abort)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int          ch;
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic [31:0] user;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          drop_q[$], abort_q[$];
  int          cyc = 0, n_chk = 0, n_fail = 0;
  logic [15:0] exp_drop = 0;
  logic [15:0] tbl_port[4];
  logic        tbl_en[4];

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic int match(input logic [15:0] dst);
    for (int k = 0; k < 4; k++)
      if (tbl_en[k] && tbl_port[k] == dst) return k;
    return -1;
  endfunction

  task automatic tbl_reset();
    for (int k = 0; k < 4; k++) begin
      tbl_port[k] = 16'h0808 + 16'(k);
      tbl_en[k]   = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge i_clk); #1;
      i_cfg_wr = 0; s_axis_ip_valid = 0; s_axis_ip_last = 0;
    end
  endtask

  task automatic cfg(input logic [1:0] a, input logic [15:0] p, input logic e);
    @(posedge i_clk); #1;
    s_axis_ip_valid = 0; s_axis_ip_last = 0;
    i_cfg_wr = 1; i_cfg_addr = a; i_cfg_port = p; i_cfg_en = e;
    tbl_port[a] = p; tbl_en[a] = e;
  endtask

  // abort_at: beat index at which valid drops instead (-1 = none).
  // mid_wr: a table write driven alongside beat 1.
  task automatic send_pkt(input logic [15:0] dst, input logic [15:0] len, input int nb,
                          input logic [7:0] klast, input int abort_at = -1,
                          input bit mid_wr = 0, input logic [1:0] wa = 0,
                          input logic [15:0] wp = 0, input logic we = 0);
    int ch;
    logic [31:0] usr;
    exp_t e;
    ch  = match(dst);
    usr = {16'd0, (len < 16'd8) ? 16'd0 : len - 16'd8};
    for (int b = 0; b < nb; b++) begin
      @(posedge i_clk); #1;
      i_cfg_wr = 0;
      if (b == abort_at) begin
        s_axis_ip_valid = 0; s_axis_ip_last = 0;
        abort_q.push_back(cyc + 2);
        return;
      end
      s_axis_ip_valid = 1;
      s_axis_ip_last  = (b == nb - 1);
      s_axis_ip_keep  = s_axis_ip_last ? klast : 8'($urandom);
      if (b == 0) begin
        s_axis_ip_data = {16'hC000 ^ 16'($urandom), dst, 32'($urandom)};
        s_axis_ip_user = {len, 8'($urandom), 32'($urandom)};
      end else begin
        s_axis_ip_data = {32'($urandom), 32'($urandom)};
        s_axis_ip_user = {24'($urandom), 32'($urandom)};
      end
      if (b == 1 && mid_wr) begin
        i_cfg_wr = 1; i_cfg_addr = wa; i_cfg_port = wp; i_cfg_en = we;
        tbl_port[wa] = wp; tbl_en[wa] = we;
      end
      if (b == 0 && nb == 1) drop_q.push_back(cyc + 2);
      else if (b > 0 && ch >= 0) begin
        e.ch = ch; e.data = s_axis_ip_data; e.last = s_axis_ip_last;
        e.keep = s_axis_ip_last ? klast : 8'hFF; e.user = usr; e.cyc = cyc + 2;
        sb_q.push_back(e);
      end else if (b == nb - 1 && ch < 0) drop_q.push_back(cyc + 2);
    end
  endtask

  always @(negedge i_clk) begin
    exp_t e;
    logic ab;
    if (!i_rst) begin
      while (drop_q.size() > 0 && drop_q[0] <= cyc) begin
        exp_drop = exp_drop + 16'd1;
        void'(drop_q.pop_front());
      end
      chk("drop_cnt", 64'(o_drop_cnt), 64'(exp_drop));
      ab = 1'b0;
      if (abort_q.size() > 0 && abort_q[0] <= cyc) begin
        ab = 1'b1;
        void'(abort_q.pop_front());
      end
      chk("abort", 64'(o_abort), 64'(ab));
      chk("onehot", 64'($onehot0(m_axis_ch_valid)), 64'd1);
      if (m_axis_ch_valid != 0) begin
        if (sb_q.size() == 0) chk("spurious_valid", 64'(m_axis_ch_valid), 64'd0);
        else begin
          e = sb_q.pop_front();
          chk("valid", 64'(m_axis_ch_valid), 64'(4'b0001 << e.ch));
          chk("data", m_axis_ch_data, e.data);
          chk("keep", 64'(m_axis_ch_keep), 64'(e.keep));
          chk("last", 64'(m_axis_ch_last), 64'(e.last));
          chk("user", 64'(m_axis_ch_user), 64'(e.user));
          chk("latency_cyc", 64'(cyc), 64'(e.cyc));
        end
      end else chk("last_wo_valid", 64'(m_axis_ch_last), 64'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl_reset();
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_data",  m_axis_ch_data, 64'd0);
    chk("rst_user",  64'(m_axis_ch_user), 64'd0);
    chk("rst_keep",  64'(m_axis_ch_keep), 64'hFF);
    chk("rst_last",  64'(m_axis_ch_last), 64'd0);
    chk("rst_valid", 64'(m_axis_ch_valid), 64'd0);
    chk("rst_drop",  64'(o_drop_cnt), 64'd0);
    chk("rst_abort", 64'(o_abort), 64'd0);
    i_rst = 0;
    idle(2);

    send_pkt(16'h0809, 16'd32, 4, 8'h0F);            // ch1, user 24
    idle(2);
    cfg(2'd2, 16'h1234, 1'b1);
    send_pkt(16'h1234, 16'd16, 2, 8'h3F);            // ch2, single beat
    idle(2);
    send_pkt(16'hBEEF, 16'd40, 5, 8'hFF);            // no match: dropped
    idle(3);

    cfg(2'd3, 16'h0808, 1'b1);
    send_pkt(16'h0808, 16'd24, 4, 8'h07, -1, 1'b1, 2'd0, 16'h0808, 1'b0);
    send_pkt(16'h0808, 16'd20, 3, 8'h1F);            // entry 0 now off: ch3
    idle(2);

    send_pkt(16'h0809, 16'd40, 5, 8'hFF, 3);         // forward abort
    send_pkt(16'h1234, 16'd20, 3, 8'h01);
    idle(1);
    send_pkt(16'hBEEF, 16'd40, 4, 8'hFF, 2);         // aborted drop: not counted
    idle(2);

    send_pkt(16'h0809, 16'd8, 1, 8'hFF);             // header-only
    send_pkt(16'h0809, 16'd5, 2, 8'h03);             // len < 8 saturates to 0
    idle(4);

    i_rst = 1;
    #3;
    chk("arst_valid", 64'(m_axis_ch_valid), 64'd0);
    chk("arst_drop",  64'(o_drop_cnt), 64'd0);
    @(posedge i_clk); #1;
    i_rst = 0;
    exp_drop = 0;
    tbl_reset();
    send_pkt(16'h1234, 16'd24, 3, 8'hFF);            // table back to default: dropped
    send_pkt(16'h080B, 16'd30, 4, 8'h3F);            // ch3
    idle(6);

    chk("sb_empty",    64'(sb_q.size()), 64'd0);
    chk("drop_q_empty", 64'(drop_q.size()), 64'd0);
    chk("abort_q_empty", 64'(abort_q.size()), 64'd0);
    chk("final_drop",  64'(o_drop_cnt), 64'd1);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/udp_rx_port_dispatch.md
# udp_rx_port_dispatch

Receive-side UDP port dispatcher between the IP receive layer and up to N user channels. It inspects the UDP header beat of each packet and matches the destination port against a runtime-programmable port table. Matched packets are forwarded, header stripped, to exactly one channel; unmatched packets are dropped and counted. It replaces the single fixed-port accept check with a configurable, multi-channel scheduler.

## Interface

Parameters:
- P_CH_NUM, 4: number of user channels; legal range 1..4.
- P_BASE_PORT, 16'h0808: reset value of table entry k is P_BASE_PORT+k, with the entry enabled.

Ports:
- i_clk  in  1  clock. All logic is on the rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_cfg_wr  in  1  one-cycle pulse; writes one port-table entry.
- i_cfg_addr  in  2  index of the table entry to write; a value ≥ P_CH_NUM is ignored.
- i_cfg_port  in  16  destination port to store.
- i_cfg_en  in  1  enable bit to store for the entry.
- s_axis_ip_data  in  64  input stream data; beat 0 is the UDP header: [63:48] source port, [47:32] destination port.
- s_axis_ip_user  in  56  input sideband; [55:40] is the UDP length in bytes, header included. Sampled on beat 0 only.
- s_axis_ip_keep  in  8  byte enables; meaningful on the last beat only.
- s_axis_ip_last  in  1  marks the last beat of a packet.
- s_axis_ip_valid  in  1  beat valid. Packets are contiguous; there is no backpressure.
- m_axis_ch_data  out  64  payload data, shared by all channels.
- m_axis_ch_user  out  32  {16'd0, payload byte count}; held for the whole packet.
- m_axis_ch_keep  out  8  8'hFF on non-last beats; the input keep on the last beat.
- m_axis_ch_last  out  1  last payload beat.
- m_axis_ch_valid  out  P_CH_NUM  one-hot valid; bit k means the beat belongs to channel k.
- o_drop_cnt  out  16  count of dropped packets; wraps at 16'hFFFF to 0.
- o_abort  out  1  one-cycle pulse when a packet ends without last.

## Operation

- Input stage: every s_axis_ip_* signal is registered unconditionally (the r-stage). The FSM and the match logic both act on the r-stage.
- Port table: P_CH_NUM entries, each {en, port[15:0]}, held in registers.
  - An i_cfg_wr write takes effect on the next edge.
  - A compare in the same cycle as a write uses the old entry value.
- Match rule: entry k matches when en=1 and port equals r-stage data[47:32]. If several entries match, the lowest k wins.
- Payload byte count: UDP length minus 8, saturating at 0 when the length is below 8.
- FSM states: IDLE, FWD, DROP. Reset state is IDLE.
- In IDLE, any r-stage valid beat is treated as a header:
  - last=1 (header-only packet): stay in IDLE, increment o_drop_cnt, forward nothing.
  - Match on channel k: latch sel=k and the payload byte count, go to FWD. The header beat itself is not forwarded.
  - No match: go to DROP.
- In FWD:
  - Each valid beat drives data, keep and last, with m_axis_ch_valid = (1<<sel).
  - A valid beat with last=1 returns the FSM to IDLE.
- In DROP:
  - Valid beats are discarded.
  - A valid beat with last=1 returns the FSM to IDLE and increments o_drop_cnt in that same cycle.
- Abort: valid low while in FWD or DROP sends the FSM to IDLE and pulses o_abort.
  - No last is emitted on the output.
  - An aborted DROP packet is not counted in o_drop_cnt.
  - The next valid beat is treated as a new header.
- Config writes during a packet do not affect the packet in flight; sel is latched at the header beat.

## Timing

- Reset values of all outputs:
  - m_axis_ch_data = 0, m_axis_ch_user = 0, m_axis_ch_keep = 8'hFF.
  - m_axis_ch_last = 0, m_axis_ch_valid = 0, o_drop_cnt = 0, o_abort = 0.
  - Port table returns to its defaults.
- Latency: a payload beat presented on s_axis at cycle t appears on m_axis_ch at cycle t+2 (input register, then output register).
- All outputs are registered.
  - m_axis_ch_valid is never asserted on more than one bit.
  - m_axis_ch_last is only asserted together with a valid bit.
- o_abort asserts 2 cycles after the first input cycle in which valid is low mid-packet.
- Back-to-back packets are supported: a header beat may immediately follow a last beat with no idle cycle.
- Reset mid-packet clears the FSM, the output registers and the table immediately, because the reset is asynchronous.

## Test plan

- Default table; a packet with dst port 16'h0809, UDP length 32, 4 beats -> 3 payload beats on channel 1 (valid=4'b0010), user=24, keep on the last beat equal to the input keep, arriving 2 cycles after the inputs.
- Write entry 2 = {en=1, port 16'h1234}, then send a 2-beat packet to 16'h1234 -> 1 beat on channel 2, last=1; o_drop_cnt unchanged.
- A packet to 16'hBEEF (no match) -> no valid bit asserted; o_drop_cnt increments 0->1 in the cycle its last beat leaves the r-stage.
- Entries 0 and 3 both set to 16'h0808 -> the packet goes to channel 0 only. A write to entry 0 mid-packet does not redirect the packet; the next packet goes to channel 3 if entry 0 was disabled.
- A 5-beat packet with valid dropped after beat 2 -> o_abort pulses once, no last is emitted, and the next 3-beat packet is dispatched correctly.
- Header-only packet (last on beat 0, length 8) followed immediately by a matching packet -> o_drop_cnt increments by 1 and the second packet is forwarded intact.
